// File: rtl/fe_mul_arbiter.sv
// fe_mul_arbiter: round-robin sharing of one fe_mulx multiplier among NREQ requesters.
// One queued request per requester; results return on a shared bus with per-requester done pulses.
module fe_mul_arbiter #(
   parameter int W    = 320,
   parameter int NREQ = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ*W-1:0] req_op_a,
   input  logic [NREQ*W-1:0] req_op_b,
   input  logic [NREQ-1:0]   req_valid,
   output logic [W-1:0]      req_res,
   output logic [NREQ-1:0]   req_done,
   output logic [NREQ-1:0]   req_err,
   output logic [W-1:0]      mul_op_a,
   output logic [W-1:0]      mul_op_b,
   output logic              mul_valid,
   input  logic [W-1:0]      mul_res,
   input  logic              mul_done
);
   localparam int IW = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t          state;
   logic [NREQ-1:0] pend;
   logic [W-1:0]    opa_q [NREQ];
   logic [W-1:0]    opb_q [NREQ];
   logic [IW-1:0]   gnt, last, nxt, idx;
   // Descending scan so the requester closest after last wins.
   always_comb begin
      nxt = last;
      idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IW'((int'(last) + k) % NREQ);
         if (pend[idx]) nxt = idx;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pend      <= '0;
         last      <= IW'(NREQ - 1);
         gnt       <= '0;
         mul_valid <= 1'b0;
         mul_op_a  <= '0;
         mul_op_b  <= '0;
         req_res   <= '0;
         req_done  <= '0;
         req_err   <= '0;
         for (int i = 0; i < NREQ; i++) begin
            opa_q[i] <= '0;
            opb_q[i] <= '0;
         end
      end else begin
         req_done  <= '0;
         mul_valid <= 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && pend[i]) req_err[i] <= 1'b1;
            if (req_valid[i] && !pend[i]) begin
               pend[i]  <= 1'b1;
               opa_q[i] <= req_op_a[i*W +: W];
               opb_q[i] <= req_op_b[i*W +: W];
            end
         end
         case (state)
            IDLE: if (|pend) begin
               gnt       <= nxt;
               mul_op_a  <= opa_q[nxt];
               mul_op_b  <= opb_q[nxt];
               mul_valid <= 1'b1;
               state     <= ISSUE;
            end
            ISSUE: state <= WAIT;
            WAIT: if (mul_done) begin
               req_res   <= mul_res;
               pend[gnt] <= 1'b0;
               last      <= gnt;
               req_done  <= NREQ'(1) << gnt;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/fe_mul_arbiter.md
# fe_mul_arbiter

Round-robin arbiter sharing a single `fe_mulx` field multiplier between up to `NREQ` requesters (e.g. `fe_invert` and a point-arithmetic sequencer). Each requester sees a multiplier-shaped port (op_a/op_b/valid in, res/done out). The arbiter captures each request's operands on a one-cycle `valid` pulse and queues one pending request per requester. It issues requests to the multiplier one at a time and routes each result back with a per-requester done pulse.

## Interface
- `W`, 320: field element width (operands and result).
- `NREQ`, 2: number of requesters, 2..4.
- `clk`  in  1: clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_op_a`  in  NREQ*W: requester operand A; requester i occupies bits [i*W +: W].
- `req_op_b`  in  NREQ*W: requester operand B, same packing.
- `req_valid`  in  NREQ: one-cycle request pulse per requester.
- `req_res`  out  W: result bus shared by all requesters; valid only while the matching `req_done` bit is high.
- `req_done`  out  NREQ: one-cycle completion pulse per requester.
- `req_err`  out  NREQ: sticky protocol-error flag per requester; cleared only by reset.
- `mul_op_a`, `mul_op_b`  out  W: operands to `fe_mulx`.
- `mul_valid`  out  1: one-cycle start pulse to `fe_mulx`.
- `mul_res`  in  W: `fe_mulx` result.
- `mul_done`  in  1: `fe_mulx` completion, sampled as a level.

## Operation
- Per requester i: `pend[i]` flag plus captured `opa_q[i]` and `opb_q[i]`.
- When `req_valid[i]` is sampled high and `pend[i]`=0: capture both operands and set `pend[i]`.
- When `req_valid[i]` is sampled high and `pend[i]`=1 (request queued or in flight, including the edge at which it completes): drop the new request, keep the old operands, and set `req_err[i]`.
- FSM states are IDLE, ISSUE and WAIT. The registers `gnt` (index) and `last` (index of the last granted requester) drive arbitration.
  - IDLE: if any `pend` bit is set, `gnt` takes the first set bit searching from `last`+1 upward with wrap-around. Go to ISSUE. Requests arriving in the same edge are not eligible until the next edge.
  - ISSUE: `mul_valid`=1 for exactly this cycle. `mul_op_a`/`mul_op_b` = `opa_q[gnt]`/`opb_q[gnt]`, held stable through WAIT. Go to WAIT.
  - WAIT: on `mul_done`=1, capture `mul_res` into `req_res`, clear `pend[gnt]`, set `last`=`gnt`, and pulse `req_done[gnt]` in the following cycle. Go to IDLE.
- `mul_done` outside WAIT is ignored, including a `mul_done` during ISSUE.
- `req_res` holds its value until the next completion.
- Only one multiplier operation is outstanding at any time.

## Timing
- Reset values: state IDLE, `pend`=0, `last`=NREQ-1 (requester 0 has first priority), `gnt`=0. All outputs are 0: `mul_valid`, `mul_op_*`, `req_res`, `req_done`, `req_err`.
- Reset mid-operation aborts everything. Queued requests are lost, and a later `mul_done` from the in-flight multiply is ignored because the FSM is no longer in WAIT.
- Latency: valid sampled at edge E0 → IDLE→ISSUE at E1 → `mul_valid` high E1..E2 → WAIT from E2.
  - `mul_done` sampled at Ed → `req_done` and `req_res` valid Ed..Ed+1.
  - Arbitration overhead is 3 cycles plus the multiplier latency.
- Back-to-back: IDLE at Ed+1 can grant the next pending request immediately.
- A requester may re-issue in the cycle its `req_done` is high: that pulse is sampled at Ed+1, when its `pend` is already clear.
- Simultaneous valids from all requesters are all captured in the same edge. They are served in round-robin order from `last`+1.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Single request, real `fe_mulx`: requester 0 sends a=320'h1, b=320'h2.
  - Exactly one `mul_valid` pulse, 2 cycles after the request.
  - `req_done`=2'b01 for one cycle with `req_res`=320'h2.
  - `req_err`=0.
- Simultaneous requests after reset: req0 (a=3, b=5) and req1 (a=7, b=11) in the same cycle.
  - Req0 is served first, then req1, with `req_done` pulses 01 then 10.
  - Results are 15 then 77, and `mul_valid` never rises while in WAIT.
- Fairness: req0 re-issues every time it gets `req_done` while req1 stays pending.
  - Grants strictly alternate 0,1,0,1 over 8 operations.
  - No requester is served twice in a row while the other is pending.
- Protocol error: req1 pulses valid again while its first request is in WAIT.
  - `req_err[1]`=1 and only one completion for req1.
  - That completion returns the first request's operands' product.
- Stray and reset: a `mul_done` pulse injected while IDLE produces no `req_done`.
  - Assert `rst` during WAIT with req0 pending: all outputs go to 0 asynchronously.
  - After release, a new req1 request completes normally.
- Invert integration: `fe_invert` on port 0 with z=320'h00053a81017f6f0affc217b7fe20238d008e7c68fe44054e0062a67b00a68f5600a2a82fffd1a58d, and a dummy multiply stream on port 1.
  - `fe_invert` output = 320'h00a7d731ff3e2b82ffb1b4c001737c3dff6b2a2801b99e9b00e91fa401bc825bff022266ff9caf02.
